// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle between two pipeline stages: upstream valid/ready with
// control+data payloads, downstream valid/ready, flush and occupancy report.
interface pipe_stage_reg_if #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 111
);
    logic              in_valid_i;
    logic              in_ready_o;
    logic [CTRL_W-1:0] in_ctrl_i;
    logic [DATA_W-1:0] in_data_i;
    logic              flush_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [CTRL_W-1:0] out_ctrl_o;
    logic [DATA_W-1:0] out_data_o;
    logic [1:0]        occupancy_o;

    modport master (
        output in_valid_i, in_ctrl_i, in_data_i, flush_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_ctrl_o, out_data_o, occupancy_o
    );

    modport slave (
        input  in_valid_i, in_ctrl_i, in_data_i, flush_i, out_ready_i,
        output in_ready_o, out_valid_o, out_ctrl_o, out_data_o, occupancy_o
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Reusable inter-stage pipeline register with valid/ready back-pressure,
// bubble insertion, flush and an optional two-entry skid buffer.
module pipe_stage_reg #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 111,
    parameter int SKID   = 1
) (
    input  logic           clk_i,
    input  logic           rst_i,
    pipe_stage_reg_if.slave bus
);
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]        state_p0;
    logic [CTRL_W-1:0] m_ctrl_p0;
    logic [DATA_W-1:0] m_data_p0;
    logic [CTRL_W-1:0] s_ctrl_p0;
    logic [DATA_W-1:0] s_data_p0;

    logic in_ready;
    logic vld_p0;
    logic in_xfer;
    logic out_xfer;

    // With the skid entry, ready comes from the state register alone so the
    // downstream ready never reaches upstream combinationally.
    always_comb begin
        vld_p0 = (state_p0 != ST_EMPTY);
        if (SKID != 0) begin
            in_ready = (state_p0 != ST_TWO);
        end else begin
            in_ready = !vld_p0 || bus.out_ready_i;
        end
        in_xfer  = bus.in_valid_i && in_ready;
        out_xfer = vld_p0 && bus.out_ready_i;
    end

    // ---- stage boundary: main entry M and skid entry S ----
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_p0  <= ST_EMPTY;
            m_ctrl_p0 <= '0;
            m_data_p0 <= '0;
            s_ctrl_p0 <= '0;
            s_data_p0 <= '0;
        end else if (bus.flush_i) begin
            // M payload is kept so out_data_o holds; only validity is dropped.
            state_p0  <= ST_EMPTY;
            s_ctrl_p0 <= '0;
            s_data_p0 <= '0;
        end else begin
            case (state_p0)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        state_p0  <= ST_ONE;
                        m_ctrl_p0 <= bus.in_ctrl_i;
                        m_data_p0 <= bus.in_data_i;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        m_ctrl_p0 <= bus.in_ctrl_i;
                        m_data_p0 <= bus.in_data_i;
                    end else if (out_xfer) begin
                        state_p0 <= ST_EMPTY;
                    end else if (in_xfer && (SKID != 0)) begin
                        state_p0  <= ST_TWO;
                        s_ctrl_p0 <= bus.in_ctrl_i;
                        s_data_p0 <= bus.in_data_i;
                    end
                end
                ST_TWO: begin
                    if (out_xfer) begin
                        state_p0  <= ST_ONE;
                        m_ctrl_p0 <= s_ctrl_p0;
                        m_data_p0 <= s_data_p0;
                    end
                end
                default: state_p0 <= ST_EMPTY;
            endcase
        end
    end

    // Control is forced to zero on bubbles so downstream sees a NOP.
    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = vld_p0;
    assign bus.out_ctrl_o  = vld_p0 ? m_ctrl_p0 : '0;
    assign bus.out_data_o  = m_data_p0;
    assign bus.occupancy_o = state_p0;
endmodule
